manchester_frame_arbiter: RTL and testbench

- Shares one Manchester-encoded serial output among NREQ requesters, each offering a DATA_W-bit payload.
- Arbitrates round-robin and captures the granted payload into a shift register.
- Serialises a framed word (start bit, source ID, payload) using the heartbeat line code: bit in the first half-period, inverted bit in the second.
- Sits between several status/counter sources and the single pad-facing heartbeat pin.

---
 rtl/manchester_frame_arbiter.sv | 175 +++++++++++++++++
 tb/tb_manchester_frame_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_arbiter.sv
// Round-robin arbiter feeding a single Manchester-coded heartbeat line.
// Each granted source's payload is framed as {start, id, payload} and sent
// MSB-first. Every bit is sent as two half-bits: first the bit, then its inverse.
//
// state | meaning
// IDLE  | line low, searching req from the round-robin pointer
// LOAD  | grant pulse, frame captured, line still low
// SEND  | shifting out 2*FRAME_BITS half-bits
// GAP   | line forced low for 2*GAP_BITS cycles
module manchester_frame_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   data,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     frame_start,
    output logic                     signal
);

    localparam int ID_W       = $clog2(NREQ);
    localparam int FRAME_BITS = 1 + ID_W + DATA_W;
    localparam int MAX_BITS   = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
    localparam int CNT_W      = $clog2(2 * MAX_BITS + 1);

    // Down-counter reload values: the counter holds the number of half-bit
    // cycles still to come after the current one, so terminal count is zero.
    localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(2 * FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_BITS > 0) ? CNT_W'(2 * GAP_BITS - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]    NREQ_X    = (ID_W + 1)'(NREQ);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  half_q, half_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  frame_start_q, frame_start_d;
    logic                  signal_q, signal_d;

    logic [2*NREQ-1:0]     req_dbl;
    logic [NREQ-1:0]       req_rot;
    logic                  win_vld;
    logic [ID_W:0]         win_sum;
    logic [ID_W-1:0]       win_id;
    logic [DATA_W-1:0]     win_data;
    logic [NREQ-1:0]       win_oh;

    // Round-robin search: rotate req so the pointer sits at bit 0, take the
    // first set bit, then map the offset back to an absolute source index.
    always_comb begin
        req_dbl  = {req, req};
        req_rot  = req_dbl[ptr_q +: NREQ];
        win_vld  = 1'b0;
        win_sum  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            end
        end
        if (win_sum >= NREQ_X) begin
            win_sum = win_sum - NREQ_X;
        end
        win_id   = win_sum[ID_W-1:0];
        win_data = '0;
        win_oh   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_data  = data[k*DATA_W +: DATA_W];
                win_oh[k] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic; line defaults to idle low.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        half_d        = half_q;
        grant_d       = '0;
        busy_d        = busy_q;
        frame_start_d = 1'b0;
        signal_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d = win_oh;
                    shift_d = {1'b1, win_id, win_data};
                    ptr_d   = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                signal_d      = shift_q[FRAME_BITS-1];
                frame_start_d = 1'b1;
                half_d        = 1'b1;
                cnt_d         = SEND_LOAD;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == '0) begin
                    if (GAP_BITS == 0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (half_q) begin
                        signal_d = ~shift_q[FRAME_BITS-1];
                        half_d   = 1'b0;
                    end else begin
                        shift_d  = shift_q << 1;
                        signal_d = shift_q[FRAME_BITS-2];
                        half_d   = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            half_q        <= 1'b0;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            signal_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            half_q        <= half_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            signal_q      <= signal_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign signal      = signal_q;

endmodule

// File: tb/tb_manchester_frame_arbiter.sv
// Testbench: random and directed stimulus for manchester_frame_arbiter; a
// transaction-level model predicts grants and frames into queues that a
// line monitor decodes and checks against.
module tb_manchester_frame_arbiter;

    localparam int NREQ = 4, DATA_W = 8, GAP_BITS = 2, ID_W = 2;
    localparam int FB = 1 + ID_W + DATA_W;
    localparam int HB = 2 * FB;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_g;
    logic [31:0] data, data_g;
    logic [3:0]  grant, grant_g;
    logic        busy, frame_start, signal;
    logic        busy_g, frame_start_g, signal_g;

    always #5 clk = ~clk;

    manchester_frame_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .GAP_BITS(GAP_BITS)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
        .busy(busy), .frame_start(frame_start), .signal(signal));

    manchester_frame_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .GAP_BITS(0)) u_gap0 (
        .clk(clk), .rst(rst), .req(req_g), .data(data_g), .grant(grant_g),
        .busy(busy_g), .frame_start(frame_start_g), .signal(signal_g));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Scoreboard queues filled by the model at each arbitration decision.
    logic [3:0]             gq[$];
    logic [ID_W+DATA_W-1:0] fq[$];

    // Model: when free, first requester at or after the pointer wins; the
    // line is then occupied for LOAD + frame + gap before the next decision.
    int m_ptr = 0, m_cnt = 0, n_grants = 0;
    bit model_on = 1'b0, drop_mode = 1'b1;

    task automatic step();
        int win;
        win = -1;
        if (model_on && !rst) begin
            if (m_cnt == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    int k;
                    k = (m_ptr + i) % NREQ;
                    if (req[k]) begin
                        win = k;
                        break;
                    end
                end
                if (win >= 0) begin
                    gq.push_back(4'(1 << win));
                    fq.push_back({ID_W'(win), data[win*DATA_W +: DATA_W]});
                    m_ptr = (win + 1) % NREQ;
                    m_cnt = 1 + 2 * FB + 2 * GAP_BITS;
                    n_grants++;
                end
            end else begin
                m_cnt--;
            end
        end
        @(posedge clk);
        #1;
        if (win >= 0 && drop_mode) req[win] = 1'b0;
        if (model_on) chk("busy", busy, m_cnt != 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (m_cnt != 0 && t < 200) begin
            step();
            t++;
        end
        repeat (2) step();
    endtask

    function automatic logic [11:0] decode(input logic [HB-1:0] s);
        logic          bad;
        logic [FB-1:0] b;
        bad = 1'b0;
        for (int i = 0; i < FB; i++) begin
            b[FB-1-i] = s[HB-1-2*i];
            if (s[HB-1-2*i] == s[HB-2-2*i]) bad = 1'b1;
        end
        return {bad, b};
    endfunction

    // Monitor: decodes frames off the line, checks grants, idle level and spacing.
    initial begin
        logic [HB-1:0] sh;
        int  sh_n, idle_run;
        bit  collecting, seen_frame;
        logic [11:0] dec;
        collecting = 0; seen_frame = 0; idle_run = 0; sh = '0; sh_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                collecting = 0; seen_frame = 0; idle_run = 0;
                gq.delete();
                fq.delete();
            end else begin
                if (grant != 4'b0) begin
                    if (gq.size() == 0) chk("grant_unexpected", grant, 4'b0);
                    else chk("grant", grant, gq.pop_front());
                end
                if (frame_start) begin
                    if (seen_frame) chk("frame_spacing", idle_run >= 2 * GAP_BITS + 2, 1);
                    seen_frame = 1;
                    collecting = 1;
                    sh   = '0;
                    sh[0] = signal;
                    sh_n = 1;
                end else if (collecting) begin
                    sh = {sh[HB-2:0], signal};
                    sh_n++;
                    if (sh_n == HB) begin
                        collecting = 0;
                        idle_run   = 0;
                        dec = decode(sh);
                        if (fq.size() == 0) chk("frame_unexpected", dec, 12'h0);
                        else chk("frame", dec, {2'b01, fq.pop_front()});
                    end
                end else begin
                    chk("idle_low", signal, 1'b0);
                    idle_run++;
                end
            end
        end
    end

    initial begin
        logic [HB-1:0] pat;
        logic          zeros, g1, found;
        logic [19:0]   seq;
        logic [3:0]    g_first;
        int            t;

        rst = 1'b1; req = '0; data = '0; req_g = '0; data_g = '0;
        for (int r = 0; r < 2; r++) begin
            req = 4'($urandom); data = $urandom; req_g = 4'($urandom); data_g = $urandom;
            @(posedge clk);
            #1;
            chk("reset_outputs", {signal, grant, busy, frame_start, signal_g, grant_g, busy_g, frame_start_g}, 12'h0);
        end
        req = '0; req_g = '0;
        rst = 1'b0;
        model_on = 1'b1;
        step();
        chk("post_reset_idle", {grant, busy, signal, frame_start}, 7'h0);

        // Single frame from source 2, payload changed after capture.
        data[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        chk("single_grant", grant, 4'b0100);
        data[23:16] = 8'h5A;
        step();
        chk("single_frame_start", frame_start, 1'b1);
        pat = '0;
        pat[0] = signal;
        repeat (HB - 1) begin
            step();
            pat = {pat[HB-2:0], signal};
        end
        chk("single_halfbits", pat, 22'b1010011001100101100110);
        zeros = 1'b0;
        repeat (2 * GAP_BITS) begin
            step();
            zeros = zeros | signal;
        end
        chk("single_gap_low", zeros, 1'b0);
        step();
        chk("single_busy_low", busy, 1'b0);

        // Round robin from a fresh pointer with all sources held.
        rst = 1'b1; m_ptr = 0; m_cnt = 0; req = '0;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) data[k*DATA_W +: DATA_W] = 8'(8'h11 * (k + 1) + k);
        drop_mode = 1'b0;
        n_grants = 0;
        seq = '0;
        req = 4'hF;
        t = 0;
        while (n_grants < 5 && t < 400) begin
            step();
            if (grant != 4'b0) seq = {seq[15:0], grant};
            t++;
        end
        req = '0;
        drain();
        chk("rr_order", seq, {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
        drop_mode = 1'b1;

        // Reset during half-bit 7 of a source-0 frame.
        data[7:0] = 8'h80;
        req = 4'b0001;
        step();
        step();
        repeat (6) step();
        chk("pre_reset_half7", signal, 1'b1);
        rst = 1'b1;
        #1;
        chk("reset_async", {signal, busy, grant, frame_start}, 7'h0);
        m_cnt = 0; m_ptr = 0; req = '0;
        step(); step();
        rst = 1'b0;
        req = 4'b1000;
        step();
        chk("reset_ptr_grant", grant, 4'b1000);
        drain();

        // A request pulse while the line is busy is lost.
        data[7:0] = 8'($urandom);
        req = 4'b0001;
        step();
        repeat (4) step();
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        g1 = 1'b0;
        t = 0;
        while (m_cnt != 0 && t < 100) begin
            step();
            g1 = g1 | grant[1];
            t++;
        end
        repeat (3) begin
            step();
            g1 = g1 | grant[1];
        end
        chk("dropped_no_grant", g1, 1'b0);
        chk("dropped_idle", {busy, signal}, 2'b00);

        // Random traffic; requesters hold until granted, data churns freely.
        repeat (1500) begin
            data = $urandom;
            if ($urandom_range(0, 3) == 0) req = req | 4'($urandom);
            step();
        end
        req = '0;
        drain();
        chk("sb_grants_drained", gq.size(), 0);
        chk("sb_frames_drained", fq.size(), 0);

        // Zero-gap build: back-to-back frames from sources 0 and 1.
        data_g = {8'h00, 8'h00, 8'hC3, 8'h3C};
        req_g = 4'b0011;
        found = 1'b0;
        g_first = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (grant_g != 4'b0 && g_first == 4'b0) g_first = grant_g;
            if (frame_start_g) found = 1'b1;
        end
        chk("g0_first_frame_seen", found, 1'b1);
        chk("g0_first_grant", g_first, 4'b0001);
        req_g[0] = 1'b0;
        repeat (HB - 1) step();
        step();
        chk("g0_idle_cycle", {signal_g, busy_g, grant_g}, 6'h0);
        step();
        chk("g0_load_cycle", {signal_g, grant_g, frame_start_g}, {1'b0, 4'b0010, 1'b0});
        req_g = '0;
        step();
        chk("g0_second_start", {frame_start_g, signal_g}, 2'b11);
        pat = '0;
        pat[0] = signal_g;
        repeat (HB - 1) begin
            step();
            pat = {pat[HB-2:0], signal_g};
        end
        chk("g0_second_frame", decode(pat), {2'b01, 2'b01, 8'hC3});
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
